// File: rtl/multimode_timer.sv
// multimode_timer
//   Four-digit BCD stopwatch/timer (SS.hh, one count step per TICK_DIV clocks)
//   driving a multiplexed four-digit 7-segment display.
//   The timer counts up or down, starting either from a fixed value or from
//   the switch preset. It stops when it reaches its terminal count.
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous active-high reset, clears all state
//   start    in   start/stop button, asynchronous to clk
//   load     in   reload button, asynchronous to clk
//   sw[15:0] in   [15:14] mode, [7:4] preset seconds tens, [3:0] preset seconds ones
//   an[3:0]  out  digit anodes, active low, an[0] = rightmost digit
//   sseg[6:0]out  segments {g,f,e,d,c,b,a}, active low
//   dp       out  decimal point, active low, lit only on digit 2
//   bcd[15:0]out  current count {d3,d2,d1,d0}
//   running  out  high while the FSM is in RUN
//   done     out  high while the FSM is in DONE
//
// Handshake: there is no valid/ready traffic. start and load are level inputs.
// Each one is synchronised and then edge-detected into a single-cycle pulse.
// That pulse is the only event the FSM acts on.
//
// Debug: o_dbg_state exposes the FSM state so checkers can bind to it.
module multimode_timer #(
  parameter int TICK_DIV    = 1000000,
  parameter int SCAN_BITS   = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load,
  input  logic [15:0] sw,
  output logic [3:0]  an,
  output logic [6:0]  sseg,
  output logic        dp,
  output logic [15:0] bcd,
  output logic        running,
  output logic        done,
  output logic [1:0]  o_dbg_state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_start_sync, r_load_sync;
  logic                   r_start_prev, r_load_prev;
  logic                   r_start_p, r_load_p;
  logic [PW-1:0]          r_presc;
  logic [SCAN_BITS-1:0]   r_scan;
  logic [15:0]            r_bcd;
  logic [1:0]             r_mode;
  logic                   r_running, r_done;

  logic [3:0]  w_pre_tens, w_pre_ones;
  logic [15:0] w_init, w_term_live, w_term_run, w_bcd_step;
  logic        w_tick, w_down;
  logic [3:0]  v_dig;
  logic        v_carry;
  logic [1:0]  w_sel;
  logic [3:0]  w_digit;
  logic        w_unused;

  // Only the mode and preset fields of sw are used.
  assign w_unused = ^sw[13:8];

  // Input synchronisers and rising-edge detectors. The pulse is registered.
  // This gives SYNC_STAGES+1 cycles from the input edge to the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_sync <= '0;
      r_load_sync  <= '0;
      r_start_prev <= 1'b0;
      r_load_prev  <= 1'b0;
      r_start_p    <= 1'b0;
      r_load_p     <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start};
      r_load_sync  <= {r_load_sync[SYNC_STAGES-2:0], load};
      r_start_prev <= r_start_sync[SYNC_STAGES-1];
      r_load_prev  <= r_load_sync[SYNC_STAGES-1];
      r_start_p    <= r_start_sync[SYNC_STAGES-1] & ~r_start_prev;
      r_load_p     <= r_load_sync[SYNC_STAGES-1] & ~r_load_prev;
    end
  end

  // Preset digits above 9 are clamped so that bcd always stays decodable.
  assign w_pre_tens = (sw[7:4] > 4'd9) ? 4'd9 : sw[7:4];
  assign w_pre_ones = (sw[3:0] > 4'd9) ? 4'd9 : sw[3:0];

  // INIT always follows the live switches. IDLE and reload both use this value.
  always_comb begin
    w_init = 16'h0000;
    case (sw[15:14])
      2'b00:   w_init = 16'h0000;
      2'b01:   w_init = {w_pre_tens, w_pre_ones, 8'h00};
      2'b10:   w_init = 16'h9999;
      default: w_init = {w_pre_tens, w_pre_ones, 8'h00};
    endcase
  end

  assign w_term_live = sw[15] ? 16'h0000 : 16'h9999;
  assign w_term_run  = r_mode[1] ? 16'h0000 : 16'h9999;
  assign w_down      = r_mode[1];
  assign w_tick      = (r_state == S_RUN) && (r_presc == TICK_MAX);

  // One BCD step with ripple carry/borrow, least significant digit first.
  always_comb begin
    w_bcd_step = r_bcd;
    v_carry    = 1'b1;
    v_dig      = 4'd0;
    for (int i = 0; i < 4; i++) begin
      v_dig = r_bcd[4*i +: 4];
      if (v_carry) begin
        if (w_down) begin
          if (v_dig == 4'd0) begin
            w_bcd_step[4*i +: 4] = 4'd9;
            v_carry              = 1'b1;
          end else begin
            w_bcd_step[4*i +: 4] = v_dig - 4'd1;
            v_carry              = 1'b0;
          end
        end else begin
          if (v_dig == 4'd9) begin
            w_bcd_step[4*i +: 4] = 4'd0;
            v_carry              = 1'b1;
          end else begin
            w_bcd_step[4*i +: 4] = v_dig + 4'd1;
            v_carry              = 1'b0;
          end
        end
      end
    end
  end

  // Next-state logic. A reload takes priority over everything else.
  always_comb begin
    w_state_next = r_state;
    if (r_load_p) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_start_p)
            w_state_next = (w_init == w_term_live) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (r_start_p)
            w_state_next = S_PAUSE;
          else if (w_tick && (w_bcd_step == w_term_run))
            w_state_next = S_DONE;
        end
        S_PAUSE: begin
          if (r_start_p) w_state_next = S_RUN;
        end
        default: w_state_next = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counter datapath. When start_p and tick fall in the same RUN cycle,
  // the counter pauses with bcd and the prescaler untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_scan    <= '0;
      r_bcd     <= 16'h0000;
      r_mode    <= 2'b00;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_scan    <= r_scan + 1'b1;
      r_running <= (w_state_next == S_RUN);
      r_done    <= (w_state_next == S_DONE);
      if (r_load_p) begin
        r_presc <= '0;
        r_bcd   <= w_init;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_presc <= '0;
            r_bcd   <= w_init;
            r_mode  <= sw[15:14];
          end
          S_RUN: begin
            if (!r_start_p) begin
              if (w_tick) begin
                r_presc <= '0;
                r_bcd   <= w_bcd_step;
              end else begin
                r_presc <= r_presc + 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Display multiplexing. The top two scan bits pick the digit.
  assign w_sel = r_scan[SCAN_BITS-1 -: 2];

  always_comb begin
    an      = 4'b1110;
    dp      = 1'b1;
    w_digit = r_bcd[3:0];
    case (w_sel)
      2'b00: begin an = 4'b1110; w_digit = r_bcd[3:0];   end
      2'b01: begin an = 4'b1101; w_digit = r_bcd[7:4];   end
      2'b10: begin an = 4'b1011; w_digit = r_bcd[11:8]; dp = 1'b0; end
      default: begin an = 4'b0111; w_digit = r_bcd[15:12]; end
    endcase
  end

  always_comb begin
    sseg = 7'b1000000;
    case (w_digit)
      4'd0:    sseg = 7'b1000000;
      4'd1:    sseg = 7'b1111001;
      4'd2:    sseg = 7'b0100100;
      4'd3:    sseg = 7'b0110000;
      4'd4:    sseg = 7'b0011001;
      4'd5:    sseg = 7'b0010010;
      4'd6:    sseg = 7'b0000010;
      4'd7:    sseg = 7'b1111000;
      4'd8:    sseg = 7'b0000000;
      4'd9:    sseg = 7'b0010000;
      default: sseg = 7'b1111111;
    endcase
  end

  assign bcd         = r_bcd;
  assign running     = r_running;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multimode_timer.sv
module tb_multimode_timer;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        load = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic [15:0] bcd;
  logic        running;
  logic        done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_bcd;
  logic [15:0] exp_v;
  logic [6:0]  seg_tab [10];
  logic [3:0]  an_tab [4];

  multimode_timer #(.TICK_DIV(4), .SCAN_BITS(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .load(load), .sw(sw),
    .an(an), .sseg(sseg), .dp(dp), .bcd(bcd), .running(running),
    .done(done), .o_dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Decimal reference model of one count step.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input bit down);
    int n;
    n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    n = down ? n - 1 : n + 1;
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Driver tasks. Each is called 1 ns after a rising edge.
  task automatic pulse_start();
    start = 1'b1; cycles(1); start = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1; cycles(1); load = 1'b0;
  endtask

  // Stop at the first sample where running is high, with a bounded wait.
  task automatic wait_running(input string tag);
    for (int i = 0; i < 20 && running !== 1'b1; i++) cycles(1);
    chk(tag, {15'd0, running}, 16'd1);
  endtask

  // Scoreboard: queue one expected value per tick, then compare on every tick.
  // The call starts at a point where the prescaler has just been cleared.
  task automatic run_ticks(input string tag, input int n, input bit down);
    for (int i = 0; i < n; i++) begin
      model_bcd = bcd_step(model_bcd, down);
      exp_q.push_back(model_bcd);
    end
    while (exp_q.size() > 0) begin
      cycles(TICK_DIV);
      exp_v = exp_q.pop_front();
      chk(tag, bcd, exp_v);
    end
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

    // Reset state
    cycles(3);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_run_done", {14'd0, running, done}, 16'd0);
    chk("rst_an", {12'd0, an}, 16'h000E);
    chk("rst_sseg", {9'd0, sseg}, 16'h0040);
    chk("rst_dp", {15'd0, dp}, 16'd1);
    reset = 1'b0;
    cycles(2);

    // Mode 00: count up, pause, resume
    sw = 16'h0000;
    cycles(2);
    pulse_start();
    wait_running("m00_run_entry");
    model_bcd = 16'h0000;
    run_ticks("m00_tick", 40, 1'b0);
    chk("m00_40_running", {15'd0, running}, 16'd1);
    // This start press lands on the cycle of tick 41, so bcd must not step.
    pulse_start();
    cycles(3);
    chk("m00_pause_state", {15'd0, running}, 16'd0);
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (bcd !== 16'h0040) begin
        chk("m00_pause_hold", bcd, 16'h0040);
        break;
      end
    end
    chk("m00_pause_end", bcd, 16'h0040);
    pulse_start();
    wait_running("m00_resume");
    chk("m00_resume_bcd", bcd, 16'h0040);
    // The prescaler stopped at its last count, so the first RUN cycle ticks.
    cycles(1);
    chk("m00_resume_41", bcd, 16'h0041);
    model_bcd = 16'h0041;
    run_ticks("m00_after_resume", 5, 1'b0);

    // Mode 01 preset 99: up to the terminal count
    sw = 16'h4099;
    pulse_load();
    cycles(6);
    chk("m01_99_idle", bcd, 16'h9900);
    chk("m01_99_idle_run", {15'd0, running}, 16'd0);
    pulse_start();
    wait_running("m01_99_run");
    model_bcd = 16'h9900;
    run_ticks("m01_99_tick", 99, 1'b0);
    chk("up_term_done", {14'd0, running, done}, 16'd1);
    cycles(50);
    pulse_start();
    cycles(10);
    chk("up_term_hold", bcd, 16'h9999);
    chk("up_term_hold_done", {14'd0, running, done}, 16'd1);

    // Mode 10: count down from 99.99
    sw = 16'h8000;
    pulse_load();
    cycles(6);
    chk("m10_idle", bcd, 16'h9999);
    chk("m10_idle_done", {15'd0, done}, 16'd0);
    pulse_start();
    wait_running("m10_run");
    model_bcd = 16'h9999;
    run_ticks("m10_tick1", 1, 1'b1);
    run_ticks("m10_tick", 99, 1'b1);
    chk("m10_9899", bcd, 16'h9899);

    // Mode 11 preset 01: count down to 00.00 with no wrap
    sw = 16'hC001;
    pulse_load();
    cycles(6);
    chk("m11_01_idle", bcd, 16'h0100);
    pulse_start();
    wait_running("m11_01_run");
    model_bcd = 16'h0100;
    run_ticks("m11_01_tick", 100, 1'b1);
    chk("dn_term_done", {14'd0, running, done}, 16'd1);
    cycles(20);
    chk("dn_term_nowrap", bcd, 16'h0000);

    // Mode 11 preset 00: start goes straight to DONE
    sw = 16'hC000;
    pulse_load();
    cycles(6);
    chk("m11_00_idle", {14'd0, running, done}, 16'd0);
    pulse_start();
    cycles(6);
    chk("m11_00_done", {14'd0, running, done}, 16'd1);
    chk("m11_00_bcd", bcd, 16'h0000);

    // Mode 11: clamped preset and a live switch change in IDLE
    sw = 16'hC03F;
    pulse_load();
    cycles(6);
    chk("m11_3F_clamp", bcd, 16'h3900);
    sw = 16'hC025;
    cycles(2);
    chk("m11_25_live", bcd, 16'h2500);
    pulse_start();
    wait_running("m11_25_run");
    model_bcd = 16'h2500;
    run_ticks("m11_25_tick", 1, 1'b1);

    // Mode 01: a switch change during RUN is ignored
    sw = 16'h4042;
    pulse_load();
    cycles(6);
    chk("m01_42_idle", bcd, 16'h4200);
    pulse_start();
    wait_running("m01_42_run");
    model_bcd = 16'h4200;
    run_ticks("m01_42_tick", 10, 1'b0);
    chk("m01_4210", bcd, 16'h4210);
    sw = 16'h8042;
    run_ticks("m01_sw_ignored", 2, 1'b0);
    pulse_load();
    cycles(6);
    chk("m01_load_bcd", bcd, 16'h9999);
    chk("m01_load_idle", {14'd0, running, done}, 16'd0);

    // Load and start in the same cycle: load wins, the FSM stays in IDLE
    start = 1'b1; load = 1'b1;
    cycles(1);
    start = 1'b0; load = 1'b0;
    cycles(8);
    chk("load_start_idle", {14'd0, running, done}, 16'd0);
    chk("load_start_bcd", bcd, 16'h9999);

    // Reset during RUN
    pulse_start();
    wait_running("rst_mid_run");
    cycles(9);
    sw = 16'h4012;
    reset = 1'b1;
    #1;
    chk("rst_mid_bcd", bcd, 16'h0000);
    chk("rst_mid_run_done", {14'd0, running, done}, 16'd0);
    chk("rst_mid_an", {12'd0, an}, 16'h000E);
    chk("rst_mid_sseg", {9'd0, sseg}, 16'h0040);
    chk("rst_mid_dp", {15'd0, dp}, 16'd1);
    cycles(2);
    reset = 1'b0;

    // Scan sequence. The count shows 12.00 once IDLE has loaded it.
    model_bcd = 16'h1200;
    for (int k = 0; k < 16; k++) begin
      chk("scan_an", {12'd0, an}, {12'd0, an_tab[k / 4]});
      chk("scan_dp", {15'd0, dp}, (k / 4 == 2) ? 16'd0 : 16'd1);
      chk("scan_sseg", {9'd0, sseg}, {9'd0, seg_tab[model_bcd[4*(k/4) +: 4]]});
      cycles(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
